ippro_decode_stage: RTL and testbench
=====================================

// Module: ippro_decode_stage
// PURPOSE
//  Instruction decode stage directly upstream of the data-forwarding unit in the IPPro datapath.
//  Accepts 32-bit instruction words and emits the per-instruction controls the next stage consumes:
//  D (dest), C (source), DSP48 OPMODE/ALUMODE and an immediate.
//  Outputs are registered behind a 2-entry skid buffer with valid/ready handshakes on both sides.
// PARAMETERS
//  DATA_W  18  width of sign-extended immediate (DSP48 B port)
//  CNT_W   16  width of retired-instruction counter
// PORTS
//  CLK        in   1       clock; all state changes on rising edge
//  RESET_N    in   1       asynchronous reset, active-low
//  ENABLE     in   1       stage enable; low = freeze all state, IN_READY forced 0
//  FLUSH      in   1       synchronous pipeline flush
//  IN_VALID   in   1       INSTR valid
//  IN_READY   out  1       stage can accept; registered (= skid buffer empty)
//  INSTR      in   32      [31:27] opcode, [26:22] D, [21:17] C, [16:12] A, [11:0] imm
//  OUT_VALID  out  1       decoded word valid
//  OUT_READY  in   1       consumer accepts decoded word
//  D          out  5       destination register
//  C          out  5       source register (C port)
//  A          out  5       source register (A port)
//  OPMODE     out  7       DSP48 OPMODE
//  ALUMODE    out  4       DSP48 ALUMODE
//  IMM        out  DATA_W  imm[11:0] sign-extended
//  USE_IMM    out  1       B operand taken from IMM
//  WE         out  1       result written back
//  ILLEGAL    out  1       sticky: undefined opcode seen
//  INSTR_CNT  out  CNT_W   count of output handshakes, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: all outputs 0 except IN_READY=1; skid and output registers empty.
//  Accept: IN_VALID & IN_READY & ENABLE. Output handshake: OUT_VALID & OUT_READY & ENABLE.
//  Opcode table (OPMODE/ALUMODE/WE/USE_IMM):
//    00000 NOP   0000000/0000/0/0, D=C=A=0
//    00001 ADD   0110011/0000/1/0
//    00010 SUB   0110011/0011/1/0
//    00011 MUL   0000101/0000/1/0
//    00100 MAC   0100101/0000/1/0
//    00101 AND   0110011/1100/1/0
//    00110 OR    0111011/1100/1/0
//    00111 XOR   0110011/0100/1/0
//    01000 LDI   0000011/0000/1/1
//    other: decoded as NOP; ILLEGAL set (cleared only by reset).
//  Latency: accepted word appears on outputs next cycle when output reg is empty or draining.
//  Output reg full, OUT_READY=0, word accepted -> word goes to skid reg; IN_READY=0 next cycle.
//  On output handshake: output reg loads skid entry if present (skid empties, IN_READY=1 next
//    cycle), else the word being accepted, else OUT_VALID=0. Program order always preserved.
//  Simultaneous accept and output handshake with skid empty: pass-through, OUT_VALID stays 1.
//  Output fields are held stable while OUT_VALID=1 and OUT_READY=0.
//  FLUSH (highest priority, works even with ENABLE=0): both entries invalidated,
//    word presented that cycle dropped, INSTR_CNT/ILLEGAL unchanged, IN_READY=1 next cycle.
//  ENABLE=0: no accept, no output handshake, counter frozen; outputs hold.
//  INSTR_CNT increments once per output handshake; 2^CNT_W-1 wraps to 0.
//  RESET_N low mid-stream: immediate clear to reset values; in-flight words lost.
// TESTING
//  Reset: RESET_N=0 -> OUT_VALID=0, IN_READY=1, OPMODE=0, INSTR_CNT=0, ILLEGAL=0.
//  ADD D=2 C=1 with OUT_READY=1 -> next cycle OUT_VALID=1, OPMODE=0110011, ALUMODE=0000, D=2, C=1, WE=1.
//  ADD(3,2), ADD(2,3), ADD(1,1) back-to-back, OUT_READY=0 for 2 cycles
//    -> IN_READY drops after 2nd accept; outputs drain in order; INSTR_CNT=3.
//  LDI imm=12'hFFE -> IMM=18'h3FFFE, USE_IMM=1.
//  Opcode 11111 -> NOP output (WE=0), ILLEGAL=1 and stays 1 after later valid words.
//  FLUSH while skid full -> OUT_VALID=0, IN_READY=1 next cycle; reset mid-stream clears; CNT_W=4 wraps 15->0.

Source files
------------

// File: rtl/ippro_decode_stage.sv
// ippro_decode_stage: decodes 32-bit IPPro instruction words into DSP48 controls.
// Decoded words sit in an output register backed by one skid entry, so the
// upstream ready can be registered without losing a word under back-pressure.
module ippro_decode_stage #(
   parameter int DATA_W = 18,
   parameter int CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              ENABLE,
   input  logic              FLUSH,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [31:0]       INSTR,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [4:0]        D,
   output logic [4:0]        C,
   output logic [4:0]        A,
   output logic [6:0]        OPMODE,
   output logic [3:0]        ALUMODE,
   output logic [DATA_W-1:0] IMM,
   output logic              USE_IMM,
   output logic              WE,
   output logic              ILLEGAL,
   output logic [CNT_W-1:0]  INSTR_CNT
);

   typedef struct packed {
      logic [4:0]        d;
      logic [4:0]        c;
      logic [4:0]        a;
      logic [6:0]        opmode;
      logic [3:0]        alumode;
      logic [DATA_W-1:0] imm;
      logic              use_imm;
      logic              we;
   } dec_t;

   // Undefined opcodes are everything above LDI.
   function automatic logic is_illegal(input logic [4:0] op);
      return (op > 5'd8);
   endfunction

   // Opcode table; NOP and undefined opcodes produce an all-zero control word.
   function automatic dec_t decode(input logic [31:0] instr);
      dec_t f;
      f         = '0;
      f.d       = instr[26:22];
      f.c       = instr[21:17];
      f.a       = instr[16:12];
      f.imm     = {{(DATA_W-12){instr[11]}}, instr[11:0]};
      case (instr[31:27])
         5'd1:    begin f.opmode = 7'b0110011; f.alumode = 4'b0000; f.we = 1'b1; end
         5'd2:    begin f.opmode = 7'b0110011; f.alumode = 4'b0011; f.we = 1'b1; end
         5'd3:    begin f.opmode = 7'b0000101; f.alumode = 4'b0000; f.we = 1'b1; end
         5'd4:    begin f.opmode = 7'b0100101; f.alumode = 4'b0000; f.we = 1'b1; end
         5'd5:    begin f.opmode = 7'b0110011; f.alumode = 4'b1100; f.we = 1'b1; end
         5'd6:    begin f.opmode = 7'b0111011; f.alumode = 4'b1100; f.we = 1'b1; end
         5'd7:    begin f.opmode = 7'b0110011; f.alumode = 4'b0100; f.we = 1'b1; end
         5'd8:    begin f.opmode = 7'b0000011; f.alumode = 4'b0000; f.we = 1'b1; f.use_imm = 1'b1; end
         default: f = '0;
      endcase
      return f;
   endfunction

   logic             in_ready_r;
   logic             out_valid_r;
   logic             skid_valid_r;
   dec_t             out_dec_r;
   dec_t             skid_dec_r;
   logic             illegal_r;
   logic [CNT_W-1:0] cnt_r;

   logic             accept_s;
   logic             out_hs_s;
   dec_t             dec_s;
   logic             out_valid_nxt_s;
   logic             skid_valid_nxt_s;
   logic             out_load_skid_s;
   logic             out_load_in_s;
   logic             skid_load_s;

   assign accept_s = IN_VALID & in_ready_r & ENABLE & ~FLUSH;
   assign out_hs_s = out_valid_r & OUT_READY & ENABLE & ~FLUSH;
   assign dec_s    = decode(INSTR);

   // Steering of the two entries: skid drains first so program order holds.
   always_comb begin
      out_valid_nxt_s  = out_valid_r;
      skid_valid_nxt_s = skid_valid_r;
      out_load_skid_s  = 1'b0;
      out_load_in_s    = 1'b0;
      skid_load_s      = 1'b0;
      if (FLUSH) begin
         out_valid_nxt_s  = 1'b0;
         skid_valid_nxt_s = 1'b0;
      end else if (out_hs_s) begin
         if (skid_valid_r) begin
            out_load_skid_s  = 1'b1;
            skid_valid_nxt_s = 1'b0;
         end else if (accept_s) begin
            out_load_in_s = 1'b1;
         end else begin
            out_valid_nxt_s = 1'b0;
         end
      end else if (accept_s) begin
         if (!out_valid_r) begin
            out_load_in_s   = 1'b1;
            out_valid_nxt_s = 1'b1;
         end else begin
            skid_load_s      = 1'b1;
            skid_valid_nxt_s = 1'b1;
         end
      end else begin
         out_valid_nxt_s = out_valid_r;
      end
   end

   // Valid bits and the registered upstream ready (ready = skid empty).
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         out_valid_r  <= 1'b0;
         skid_valid_r <= 1'b0;
         in_ready_r   <= 1'b1;
      end else begin
         out_valid_r  <= out_valid_nxt_s;
         skid_valid_r <= skid_valid_nxt_s;
         in_ready_r   <= ~skid_valid_nxt_s;
      end
   end

   // Decoded payload registers; held whenever not explicitly loaded.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         out_dec_r  <= '0;
         skid_dec_r <= '0;
      end else begin
         if (out_load_skid_s) begin
            out_dec_r <= skid_dec_r;
         end else if (out_load_in_s) begin
            out_dec_r <= dec_s;
         end
         if (skid_load_s) begin
            skid_dec_r <= dec_s;
         end
      end
   end

   // Retired-instruction counter and sticky illegal flag; flush leaves both alone.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt_r     <= '0;
         illegal_r <= 1'b0;
      end else begin
         if (out_hs_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if (accept_s && is_illegal(INSTR[31:27])) begin
            illegal_r <= 1'b1;
         end
      end
   end

   assign IN_READY  = in_ready_r & ENABLE;
   assign OUT_VALID = out_valid_r;
   assign D         = out_dec_r.d;
   assign C         = out_dec_r.c;
   assign A         = out_dec_r.a;
   assign OPMODE    = out_dec_r.opmode;
   assign ALUMODE   = out_dec_r.alumode;
   assign IMM       = out_dec_r.imm;
   assign USE_IMM   = out_dec_r.use_imm;
   assign WE        = out_dec_r.we;
   assign ILLEGAL   = illegal_r;
   assign INSTR_CNT = cnt_r;

endmodule

// File: tb/tb_ippro_decode_stage.sv
// Bench for ippro_decode_stage: directed steps followed by random traffic,
// checked each cycle against a queue-based model of the in-flight words.
module tb_ippro_decode_stage;

   localparam int DATA_W = 18;
   localparam int CNT_W  = 4;

   logic              CLK = 1'b0;
   logic              RESET_N, ENABLE, FLUSH, IN_VALID, IN_READY, OUT_VALID, OUT_READY;
   logic [31:0]       INSTR;
   logic [4:0]        D, C, A;
   logic [6:0]        OPMODE;
   logic [3:0]        ALUMODE;
   logic [DATA_W-1:0] IMM;
   logic              USE_IMM, WE, ILLEGAL;
   logic [CNT_W-1:0]  INSTR_CNT;

   ippro_decode_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .FLUSH(FLUSH),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY), .INSTR(INSTR),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
      .D(D), .C(C), .A(A), .OPMODE(OPMODE), .ALUMODE(ALUMODE), .IMM(IMM),
      .USE_IMM(USE_IMM), .WE(WE), .ILLEGAL(ILLEGAL), .INSTR_CNT(INSTR_CNT)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   // Model: words accepted but not yet handed downstream, in program order.
   logic [31:0]      q[$];
   logic [CNT_W-1:0] m_cnt = '0;
   logic             m_ill = 1'b0;

   function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] d,
                                      input logic [4:0] c, input logic [4:0] a,
                                      input logic [11:0] imm);
      return {op, d, c, a, imm};
   endfunction

   // Expected {D,C,A,OPMODE,ALUMODE,IMM,USE_IMM,WE} from the opcode table.
   function automatic logic [63:0] expect_fields(input logic [31:0] w);
      logic [6:0]        om;
      logic [3:0]        am;
      logic              we, ui;
      logic [DATA_W-1:0] imm;
      logic [11:0]       raw;
      logic [4:0]        op;
      op  = w[31:27];
      raw = w[11:0];
      imm = DATA_W'($signed(raw));
      we  = (op >= 5'd1 && op <= 5'd8);
      ui  = (op == 5'd8);
      om  = 7'd0;
      am  = 4'd0;
      case (op)
         5'd1, 5'd7: om = 7'b0110011;
         5'd2: begin om = 7'b0110011; am = 4'b0011; end
         5'd3: om = 7'b0000101;
         5'd4: om = 7'b0100101;
         5'd5: begin om = 7'b0110011; am = 4'b1100; end
         6'd6: begin om = 7'b0111011; am = 4'b1100; end
         5'd8: om = 7'b0000011;
         default: om = 7'd0;
      endcase
      if (op == 5'd7) am = 4'b0100;
      if (!we) return 64'd0;
      return 64'({w[26:22], w[21:17], w[16:12], om, am, imm, ui, we});
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle, entered and left at a falling edge: drive, check, clock, update model.
   task automatic step(input logic iv, input logic [31:0] w, input logic rdy,
                       input logic en, input logic fl);
      logic acc, hs;
      IN_VALID = iv; INSTR = w; OUT_READY = rdy; ENABLE = en; FLUSH = fl;
      #1;
      chk("out_valid", 64'(OUT_VALID), 64'(q.size() > 0));
      chk("in_ready", 64'(IN_READY), 64'(en && q.size() < 2));
      if (q.size() > 0)
         chk("fields", 64'({D, C, A, OPMODE, ALUMODE, IMM, USE_IMM, WE}), expect_fields(q[0]));
      chk("instr_cnt", 64'(INSTR_CNT), 64'(m_cnt));
      chk("illegal", 64'(ILLEGAL), 64'(m_ill));
      acc = iv && en && (q.size() < 2) && !fl;
      hs  = (q.size() > 0) && rdy && en && !fl;
      @(posedge CLK);
      if (fl) begin
         q.delete();
      end else begin
         if (hs) begin
            void'(q.pop_front());
            m_cnt = m_cnt + 4'd1;
         end
         if (acc) begin
            q.push_back(w);
            if (w[31:27] > 5'd8) m_ill = 1'b1;
         end
      end
      @(negedge CLK);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET_N = 1'b0;
      #1;
      q.delete();
      m_cnt = '0;
      m_ill = 1'b0;
      chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
      chk("rst_in_ready", 64'(IN_READY), 64'd1);
      chk("rst_opmode", 64'(OPMODE), 64'd0);
      chk("rst_cnt", 64'(INSTR_CNT), 64'd0);
      chk("rst_illegal", 64'(ILLEGAL), 64'd0);
      @(negedge CLK);
      RESET_N = 1'b1;
   endtask

   initial begin
      logic [31:0] w;
      logic [4:0]  op;
      RESET_N = 1'b0; ENABLE = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0;
      OUT_READY = 1'b0; INSTR = 32'd0;
      #12;
      do_reset();

      // Single ADD D=2 C=1 with the consumer ready.
      step(1'b1, mk(5'd1, 5'd2, 5'd1, 5'd0, 12'd0), 1'b1, 1'b1, 1'b0);
      chk("add_valid", 64'(OUT_VALID), 64'd1);
      chk("add_opmode", 64'(OPMODE), 64'(7'b0110011));
      chk("add_alumode", 64'(ALUMODE), 64'(4'b0000));
      chk("add_dc", 64'({D, C, WE}), 64'({5'd2, 5'd1, 1'b1}));
      step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);

      // Back-to-back under back-pressure, then drain in order.
      do_reset();
      step(1'b1, mk(5'd1, 5'd3, 5'd2, 5'd0, 12'd0), 1'b0, 1'b1, 1'b0);
      step(1'b1, mk(5'd1, 5'd2, 5'd3, 5'd0, 12'd0), 1'b0, 1'b1, 1'b0);
      chk("b2b_in_ready", 64'(IN_READY), 64'd0);
      step(1'b1, mk(5'd1, 5'd1, 5'd1, 5'd0, 12'd0), 1'b0, 1'b1, 1'b0);
      step(1'b1, mk(5'd1, 5'd1, 5'd1, 5'd0, 12'd0), 1'b1, 1'b1, 1'b0);
      step(1'b1, mk(5'd1, 5'd1, 5'd1, 5'd0, 12'd0), 1'b1, 1'b1, 1'b0);
      step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
      chk("b2b_cnt", 64'(INSTR_CNT), 64'd3);
      chk("b2b_empty", 64'(OUT_VALID), 64'd0);

      // LDI sign-extension.
      step(1'b1, mk(5'd8, 5'd4, 5'd0, 5'd0, 12'hFFE), 1'b0, 1'b1, 1'b0);
      chk("ldi_imm", 64'(IMM), 64'(18'h3FFFE));
      chk("ldi_use_imm", 64'(USE_IMM), 64'd1);
      step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);

      // Undefined opcode: NOP output, sticky ILLEGAL.
      step(1'b1, mk(5'h1F, 5'd7, 5'd7, 5'd7, 12'h123), 1'b1, 1'b1, 1'b0);
      chk("ill_flag", 64'(ILLEGAL), 64'd1);
      chk("ill_nop", 64'({OUT_VALID, WE, OPMODE, D}), 64'({1'b1, 1'b0, 7'd0, 5'd0}));
      step(1'b1, mk(5'd2, 5'd5, 5'd6, 5'd7, 12'd0), 1'b1, 1'b1, 1'b0);
      step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
      chk("ill_sticky", 64'(ILLEGAL), 64'd1);

      // Flush with the skid entry occupied.
      step(1'b1, mk(5'd3, 5'd1, 5'd2, 5'd3, 12'd0), 1'b0, 1'b1, 1'b0);
      step(1'b1, mk(5'd4, 5'd4, 5'd5, 5'd6, 12'd0), 1'b0, 1'b1, 1'b0);
      chk("pre_flush_in_ready", 64'(IN_READY), 64'd0);
      step(1'b1, mk(5'd5, 5'd1, 5'd1, 5'd1, 12'd0), 1'b0, 1'b1, 1'b1);
      chk("flush_valid", 64'(OUT_VALID), 64'd0);
      chk("flush_in_ready", 64'(IN_READY), 64'd1);

      // Reset in the middle of traffic.
      step(1'b1, mk(5'd6, 5'd1, 5'd2, 5'd3, 12'd0), 1'b0, 1'b1, 1'b0);
      step(1'b1, mk(5'd7, 5'd3, 5'd2, 5'd1, 12'd0), 1'b0, 1'b1, 1'b0);
      do_reset();

      // Counter wrap at CNT_W=4: 15 handshakes then one more.
      for (int i = 0; i < 16; i++)
         step(1'b1, mk(5'd1, 5'(i), 5'd1, 5'd2, 12'd0), 1'b1, 1'b1, 1'b0);
      chk("cnt_15", 64'(INSTR_CNT), 64'd15);
      step(1'b1, mk(5'd0, 5'd0, 5'd0, 5'd0, 12'd0), 1'b1, 1'b1, 1'b0);
      chk("cnt_wrap", 64'(INSTR_CNT), 64'd0);

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         op = 5'($urandom_range(0, 8));
         if ($urandom_range(0, 9) == 0) op = 5'($urandom_range(9, 31));
         w = {op, 27'($urandom)};
         step(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 24) == 0));
      end
      step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
